// File: rtl/vec_tx_serializer.sv
// rtl/vec_tx_serializer.sv - snapshots a LENGTH x WIDTH vector and streams it byte-wise to a UART
// Element 0 first, least-significant byte first; one start/busy handshake per byte.
module vec_tx_serializer #(
   parameter int WIDTH  = 8,
   parameter int LENGTH = 1024
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] vec_in [LENGTH-1:0],
   input  logic             calc_ready,
   input  logic             tx_busy,
   output logic [7:0]       tx_data,
   output logic             tx_start,
   output logic             is_transmitting,
   output logic             op_finished
);
   localparam int BYTES = WIDTH / 8;
   localparam int EW    = (LENGTH > 1) ? $clog2(LENGTH) : 1;
   localparam int BW    = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam logic [EW-1:0] ELEM_LAST = EW'(LENGTH - 1);
   localparam logic [BW-1:0] BYTE_LAST = BW'(BYTES - 1);

   typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_ACK, WAIT_DONE, FINISH} state_t;

   state_t           state_q, state_d;
   logic [EW-1:0]    elem_idx_q, elem_idx_d;
   logic [BW-1:0]    byte_idx_q, byte_idx_d;
   logic             armed_q, armed_d;
   logic [7:0]       tx_data_q, tx_data_d;
   logic [WIDTH-1:0] snap_q [LENGTH-1:0];
   logic [WIDTH-1:0] cur_elem;
   logic             snap_en;

   assign cur_elem = snap_q[elem_idx_q];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         elem_idx_q <= '0;
         byte_idx_q <= '0;
         armed_q    <= 1'b1;
         tx_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         elem_idx_q <= elem_idx_d;
         byte_idx_q <= byte_idx_d;
         armed_q    <= armed_d;
         tx_data_q  <= tx_data_d;
      end
   end

   // Snapshot is only meaningful after a capture, so it carries no reset.
   always_ff @(posedge clk) begin
      if (snap_en) snap_q <= vec_in;
   end

   always_comb begin
      state_d    = state_q;
      elem_idx_d = elem_idx_q;
      byte_idx_d = byte_idx_q;
      armed_d    = armed_q;
      tx_data_d  = tx_data_q;
      snap_en    = 1'b0;
      tx_start   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!calc_ready) begin
               armed_d = 1'b1;
            end else if (armed_q) begin
               armed_d = 1'b0;
               snap_en = 1'b1;
               state_d = LOAD;
            end
         end
         LOAD: begin
            tx_data_d = 8'(cur_elem >> {byte_idx_q, 3'b000});
            state_d   = START;
         end
         START: begin
            if (!tx_busy) begin
               tx_start = 1'b1;
               state_d  = WAIT_ACK;
            end
         end
         WAIT_ACK: begin
            if (tx_busy) state_d = WAIT_DONE;
         end
         WAIT_DONE: begin
            if (!tx_busy) begin
               state_d = LOAD;
               if (byte_idx_q != BYTE_LAST) begin
                  byte_idx_d = byte_idx_q + BW'(1);
               end else if (elem_idx_q != ELEM_LAST) begin
                  byte_idx_d = '0;
                  elem_idx_d = elem_idx_q + EW'(1);
               end else begin
                  state_d = FINISH;
               end
            end
         end
         FINISH: begin
            elem_idx_d = '0;
            byte_idx_d = '0;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign tx_data         = tx_data_q;
   assign is_transmitting = (state_q != IDLE);
   assign op_finished     = (state_q == FINISH);

endmodule
